// File: rtl/airport_decoder.sv
// Runway wind-light decoder: classifies lamp-pattern transitions and locks onto a wind code.
// Optional saturating error counter output enabled by AIRPORT_DECODER_ERRCNT_EN.
module airport_decoder #(
  parameter int unsigned LOCK_CNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] lights,
  input  logic       lights_vld,
  output logic [1:0] w,
  output logic       locked,
  output logic       err
`ifdef AIRPORT_DECODER_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic [1:0] {StEmpty, StTrack, StLock} state_e;

  localparam logic [1:0] ClsCalm = 2'b00;
  localparam logic [1:0] ClsRtl  = 2'b01;
  localparam logic [1:0] ClsLtr  = 2'b10;
  localparam logic [3:0] LockCnt = 4'(LOCK_CNT);

  state_e     r_state, w_state_nxt;
  logic [2:0] r_prev, w_prev_nxt;
  logic [1:0] r_cls, w_cls_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [1:0] r_w, w_w_nxt;
  logic       r_locked, w_locked_nxt;
  logic       r_err, w_err_nxt;

  logic       w_legal;
  logic       w_trans_ok;
  logic [1:0] w_trans_cls;
  logic [3:0] w_cnt_inc;

  always_comb begin
    unique case (lights)
      3'b101, 3'b010, 3'b100, 3'b001: w_legal = 1'b1;
      default:                        w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_trans_ok  = 1'b1;
    w_trans_cls = ClsCalm;
    case ({r_prev, lights})
      6'b101_010, 6'b010_101:             w_trans_cls = ClsCalm;
      6'b100_010, 6'b010_001, 6'b001_100: w_trans_cls = ClsRtl;
      6'b001_010, 6'b010_100, 6'b100_001: w_trans_cls = ClsLtr;
      default:                            w_trans_ok  = 1'b0;
    endcase
  end

  // Count saturates at the lock threshold; a zero count means no running class yet.
  assign w_cnt_inc = (r_cnt >= LockCnt) ? r_cnt : r_cnt + 4'd1;

  always_comb begin
    w_state_nxt  = r_state;
    w_prev_nxt   = r_prev;
    w_cls_nxt    = r_cls;
    w_cnt_nxt    = r_cnt;
    w_w_nxt      = r_w;
    w_locked_nxt = r_locked;
    w_err_nxt    = 1'b0;
    if (lights_vld) begin
      if (!w_legal) begin
        w_err_nxt    = 1'b1;
        w_locked_nxt = 1'b0;
        w_state_nxt  = StEmpty;
        w_cnt_nxt    = 4'd0;
      end else if (r_state == StEmpty) begin
        w_prev_nxt  = lights;
        w_state_nxt = StTrack;
        w_cnt_nxt   = 4'd0;
      end else begin
        w_prev_nxt = lights;
        if (!w_trans_ok) begin
          w_err_nxt    = 1'b1;
          w_locked_nxt = 1'b0;
          w_state_nxt  = StTrack;
          w_cnt_nxt    = 4'd0;
        end else if (r_cnt == 4'd0 || w_trans_cls == r_cls) begin
          w_cls_nxt = w_trans_cls;
          w_cnt_nxt = w_cnt_inc;
          if (r_state == StTrack && w_cnt_inc == LockCnt) begin
            w_w_nxt      = w_trans_cls;
            w_locked_nxt = 1'b1;
            w_state_nxt  = StLock;
          end
        end else begin
          w_cls_nxt    = w_trans_cls;
          w_cnt_nxt    = 4'd1;
          w_locked_nxt = 1'b0;
          w_state_nxt  = StTrack;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= StEmpty;
      r_prev   <= 3'b000;
      r_cls    <= ClsCalm;
      r_cnt    <= 4'd0;
      r_w      <= 2'b00;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_prev   <= w_prev_nxt;
      r_cls    <= w_cls_nxt;
      r_cnt    <= w_cnt_nxt;
      r_w      <= w_w_nxt;
      r_locked <= w_locked_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign w      = r_w;
  assign locked = r_locked;
  assign err    = r_err;

`ifdef AIRPORT_DECODER_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_cnt <= 8'd0;
    end else if (w_err_nxt && r_err_cnt != 8'hff) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_airport_decoder.sv
// Scoreboard bench for airport_decoder: directed samples push expected {w,locked,err}.
module tb_airport_decoder;

  logic       clk;
  logic       reset;
  logic [2:0] lights;
  logic       lights_vld;
  logic [1:0] w;
  logic       locked;
  logic       err;
`ifdef AIRPORT_DECODER_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  typedef struct packed {
    logic [1:0] w;
    logic       lk;
    logic       er;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   sample_no = 0;
  logic mon_seen;
  exp_t mon_exp;

  airport_decoder #(.LOCK_CNT(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .lights    (lights),
    .lights_vld(lights_vld),
    .w         (w),
    .locked    (locked),
    .err       (err)
`ifdef AIRPORT_DECODER_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every sampled input yields a response one cycle later.
  always @(posedge clk) begin
    mon_seen = lights_vld && reset;
    #1;
    if (mon_seen) begin
      sample_no++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got response for sample %0d expected none", sample_no);
      end else begin
        mon_exp = q.pop_front();
        chk($sformatf("sample%0d {w,locked,err}", sample_no), {28'd0, w, locked, err},
            {28'd0, mon_exp});
      end
    end else begin
      chk("err_idle", {31'd0, err}, 32'd0);
    end
  end

  task automatic send(input logic [2:0] p, input logic [1:0] ew, input logic el,
                      input logic ee);
    @(negedge clk);
    lights     = p;
    lights_vld = 1'b1;
    q.push_back('{w: ew, lk: el, er: ee});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      lights_vld = 1'b0;
      lights     = 3'b111;
    end
  endtask

  task automatic do_reset();
    idle(2);
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);
  endtask

  initial begin
    reset      = 1'b0;
    lights     = 3'b000;
    lights_vld = 1'b0;
    idle(3);
    chk("reset_w", {30'd0, w}, 32'd0);
    chk("reset_locked", {31'd0, locked}, 32'd0);
    reset = 1'b1;
    idle(1);

    // CALM lock, then illegal pattern and relock from EMPTY
    send(3'b101, 2'b00, 1'b0, 1'b0);
    send(3'b010, 2'b00, 1'b0, 1'b0);
    send(3'b101, 2'b00, 1'b0, 1'b0);
    send(3'b010, 2'b00, 1'b1, 1'b0);
    send(3'b111, 2'b00, 1'b0, 1'b1);
    send(3'b101, 2'b00, 1'b0, 1'b0);
    send(3'b010, 2'b00, 1'b0, 1'b0);
    send(3'b101, 2'b00, 1'b0, 1'b0);
    send(3'b010, 2'b00, 1'b1, 1'b0);
    // Repeated 010: err, count 0, 010 becomes previous so three transitions relock
    send(3'b010, 2'b00, 1'b0, 1'b1);
    send(3'b101, 2'b00, 1'b0, 1'b0);
    send(3'b010, 2'b00, 1'b0, 1'b0);
    send(3'b101, 2'b00, 1'b1, 1'b0);
    do_reset();

    // RtL lock, class change to LtR, LtR lock, illegal pattern holds w
    send(3'b100, 2'b00, 1'b0, 1'b0);
    send(3'b010, 2'b00, 1'b0, 1'b0);
    send(3'b001, 2'b00, 1'b0, 1'b0);
    send(3'b100, 2'b01, 1'b1, 1'b0);
    send(3'b001, 2'b01, 1'b0, 1'b0);
    send(3'b010, 2'b01, 1'b0, 1'b0);
    send(3'b100, 2'b10, 1'b1, 1'b0);
    send(3'b001, 2'b10, 1'b1, 1'b0);
    send(3'b110, 2'b10, 1'b0, 1'b1);
    send(3'b001, 2'b10, 1'b0, 1'b0);
    do_reset();

    // Gaps with illegal values while lights_vld is low
    send(3'b100, 2'b00, 1'b0, 1'b0);
    idle(5);
    send(3'b010, 2'b00, 1'b0, 1'b0);
    idle(5);
    send(3'b001, 2'b00, 1'b0, 1'b0);
    idle(5);
    send(3'b100, 2'b01, 1'b1, 1'b0);
    idle(2);

    // Asynchronous reset between edges while locked
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_w", {30'd0, w}, 32'd0);
    chk("async_reset_locked", {31'd0, locked}, 32'd0);
    idle(2);
    reset = 1'b1;
    idle(1);

`ifdef AIRPORT_DECODER_ERRCNT_EN
    chk("err_cnt_reset", {24'd0, err_cnt}, 32'd0);
    repeat (3) send(3'b000, 2'b00, 1'b0, 1'b1);
    idle(2);
    chk("err_cnt_3", {24'd0, err_cnt}, 32'd3);
    repeat (297) send(3'b111, 2'b00, 1'b0, 1'b1);
    idle(2);
    chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
`endif

    idle(3);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/airport_decoder.md
AIRPORT_DECODER -- requirements
Module: airport_decoder

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 3, meaning the number of consecutive same-class legal transitions required to declare lock (range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port lights, input, 3 bits: the observed runway lamp pattern.
REQ-005 SHALL have port lights_vld, input, 1 bit: when high, lights is sampled this cycle.
REQ-006 SHALL have port w, output, 2 bits: decoded wind code (00 calm, 01 right-to-left, 10 left-to-right).
REQ-007 SHALL have port locked, output, 1 bit: high while w reflects a confirmed current pattern.
REQ-008 SHALL have port err, output, 1 bit: one-cycle pulse on an illegal pattern or illegal transition.

Function
REQ-009 SHALL accept only legal patterns 101, 010, 100 and 001; patterns 000, 011, 110 and 111 are illegal.
REQ-010 SHALL classify each sampled transition (previous pattern -> current pattern) as follows.
- CALM: 101->010 or 010->101.
- RtL: 100->010, 010->001 or 001->100.
- LtR: 001->010, 010->100 or 100->001.
REQ-011 SHALL treat any other transition, including a repeated pattern, as illegal.
REQ-012 SHALL implement FSM states EMPTY (no previous pattern), TRACK (counting) and LOCK.
REQ-013 SHALL, in EMPTY, on a legal sample: store it as previous and go to TRACK with count=0.
REQ-014 SHALL, in TRACK, on a legal transition of the same class as the running class (or the first classified transition): increment count.
REQ-015 SHALL, in TRACK, on reaching count==LOCK_CNT: load w with the class, assert locked and go to LOCK, all in the same clock edge.
REQ-016 SHALL, in TRACK or LOCK, on a legal transition of a different class: set running class to the new class, set count=1, deassert locked, go to TRACK, and hold w.
REQ-017 SHALL, in any state, on an illegal pattern: pulse err, deassert locked, go to EMPTY, and hold w.
REQ-018 SHALL, in TRACK or LOCK, on an illegal transition between legal patterns: pulse err, deassert locked, store the current pattern as previous, go to TRACK with count=0, and hold w.
REQ-019 SHALL, in LOCK, on a same-class transition: remain in LOCK with w unchanged.
REQ-020 SHALL hold all state when lights_vld=0; gaps between samples are not errors.
REQ-021 SHALL register outputs; the response appears the cycle after the sampling edge.
REQ-022 SHALL, when LOCK_CNT=1, lock on the first legal classified transition.
REQ-023 SHALL saturate the count at LOCK_CNT.

Reset
REQ-024 SHALL, on reset=0 regardless of clk: enter EMPTY, set w=00, locked=0, err=0 and count=0, and clear the stored previous pattern.
REQ-025 SHALL, on reset deassertion mid-sequence, treat the next valid sample as the first sample.

Configuration
REQ-026 SHALL use macro AIRPORT_DECODER_ERRCNT_EN.
- When defined: add output err_cnt, 8 bits, which increments on each err pulse, saturates at 255, and resets to 0.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Verification
REQ-027 SHALL cover: reset, then lights_vld=1 each cycle with 101,010,101,010 -> locked=1 and w=00 the cycle after the 4th sample; err never pulses.
REQ-028 SHALL cover: 100,010,001,100 -> w=01 and locked=1 after the 4th sample; then 100->001 -> locked drops and class LtR count=1; two more LtR transitions -> w=10 and locked=1.
REQ-029 SHALL cover: while locked on CALM, inject 111 -> err pulses for one cycle, locked=0, w holds 00; FSM is in EMPTY and needs 4 legal samples to relock.
REQ-030 SHALL cover: repeated 010,010 -> err pulse, count=0; 010 becomes the new previous pattern.
REQ-031 SHALL cover: legal sequence with lights_vld low for 5 cycles between samples -> lock occurs identically; illegal values presented while lights_vld=0 are ignored.
REQ-032 SHALL cover: assert reset asynchronously between clock edges while locked -> w=00 and locked=0 immediately; with AIRPORT_DECODER_ERRCNT_EN defined, 300 err pulses -> err_cnt=255.
